mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 122 ++++++++++++
 tb/tb_mult_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mult_arbiter
// Brief    : Round-robin arbiter sharing one signed Q2.14 multiplier across
//            NREQ requesters, with a LAT-stage stallable result pipeline.
// Revision : 1.0
// ============================================================================
module mult_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [16*NREQ-1:0]      req_a,
    input  logic [16*NREQ-1:0]      req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    output logic [$clog2(NREQ)-1:0] resp_id,
    output logic [15:0]             resp_data,
    output logic                    resp_ovf,
    input  logic                    resp_ready,
    output logic                    busy
);

    localparam int                c_IDW     = $clog2(NREQ);
    localparam logic [c_IDW-1:0] c_PTR_RST = c_IDW'(NREQ - 1);

    logic [c_IDW-1:0] r_ptr;
    logic [LAT-1:0]   r_valid;
    logic [c_IDW-1:0] r_id   [LAT];
    logic [15:0]      r_data [LAT];
    logic             r_ovf  [LAT];

    logic               w_stall;
    logic               w_found;
    logic               w_xfer;
    logic [c_IDW-1:0]   w_gid;
    int                 w_sum;
    logic signed [15:0] w_a;
    logic signed [15:0] w_b;
    logic signed [31:0] w_prod;
    logic [15:0]        w_data;
    logic               w_ovf;
    logic               w_unused;

    assign w_stall = r_valid[LAT-1] & ~resp_ready;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_sum   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_sum = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_sum[c_IDW-1:0]]) begin
                w_found = 1'b1;
                w_gid   = w_sum[c_IDW-1:0];
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gid == c_IDW'(i)) begin
                w_a = req_a[16*i +: 16];
                w_b = req_b[16*i +: 16];
            end
        end
    end

    assign w_xfer = w_found & ~w_stall;

    always_comb begin
        req_ready = '0;
        if (w_xfer && rst_n) begin
            req_ready[w_gid] = 1'b1;
        end
    end

    // Taking P[29:14] is a floor divide by 2^14; overflow means the top three bits disagree.
    assign w_prod   = w_a * w_b;
    assign w_data   = w_prod[29:14];
    assign w_ovf    = ~((w_prod[31:29] == 3'b000) | (w_prod[31:29] == 3'b111));
    assign w_unused = &{1'b0, w_prod[13:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= c_PTR_RST;
            r_valid <= '0;
            for (int s = 0; s < LAT; s++) begin
                r_id[s]   <= '0;
                r_data[s] <= '0;
                r_ovf[s]  <= 1'b0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= w_xfer;
            r_id[0]    <= w_gid;
            r_data[0]  <= w_data;
            r_ovf[0]   <= w_ovf;
            for (int s = 1; s < LAT; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_id[s]    <= r_id[s-1];
                r_data[s]  <= r_data[s-1];
                r_ovf[s]   <= r_ovf[s-1];
            end
            if (w_xfer) begin
                r_ptr <= w_gid;
            end
        end
    end

    assign resp_valid = r_valid[LAT-1];
    assign resp_id    = r_id[LAT-1];
    assign resp_data  = r_data[LAT-1];
    assign resp_ovf   = r_ovf[LAT-1];
    assign busy       = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_arbiter
// Brief    : Self-checking bench for mult_arbiter against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [16*NREQ-1:0]   req_a;
    logic [16*NREQ-1:0]   req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic [1:0]           resp_id;
    logic [15:0]          resp_data;
    logic                 resp_ovf;
    logic                 resp_ready;
    logic                 busy;

    mult_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .resp_ready (resp_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: in-flight results as a delay line plus the last winner.
    logic        m_v [LAT];
    logic [1:0]  m_id[LAT];
    logic [15:0] m_d [LAT];
    logic        m_o [LAT];
    int          m_ptr;

    logic [NREQ-1:0] exp_ready;
    logic            exp_valid, exp_busy, exp_ovf, exp_stall, exp_xfer;
    logic [1:0]      exp_id;
    logic [15:0]     exp_data;
    int              exp_gid;

    function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                    output logic [15:0] d, output logic o);
        longint p, q;
        p = longint'($signed(a)) * longint'($signed(b));
        q = p >>> 14;
        d = q[15:0];
        o = (p > 536870911) || (p < -536870912);
    endfunction

    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = rnd_op();
            req_b[16*i +: 16] = rnd_op();
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < LAT; s++) m_v[s] = 1'b0;
        m_ptr = NREQ - 1;
    endtask

    task automatic model_eval();
        int idx;
        exp_stall = m_v[LAT-1] && !resp_ready;
        exp_xfer  = 1'b0;
        exp_gid   = 0;
        if (rst_n && !exp_stall) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + 1 + k) % NREQ;
                if (!exp_xfer && req_valid[idx]) begin
                    exp_xfer = 1'b1;
                    exp_gid  = idx;
                end
            end
        end
        exp_ready = '0;
        if (exp_xfer) exp_ready[exp_gid] = 1'b1;
        exp_valid = m_v[LAT-1];
        exp_id    = m_id[LAT-1];
        exp_data  = m_d[LAT-1];
        exp_ovf   = m_o[LAT-1];
        exp_busy  = 1'b0;
        for (int s = 0; s < LAT; s++) exp_busy |= m_v[s];
    endtask

    task automatic tick();
        logic [15:0] d;
        logic        o;
        @(posedge clk);
        if (!exp_stall) begin
            for (int s = LAT - 1; s > 0; s--) begin
                m_v[s] = m_v[s-1]; m_id[s] = m_id[s-1];
                m_d[s] = m_d[s-1]; m_o[s]  = m_o[s-1];
            end
            ref_mul(req_a[16*exp_gid +: 16], req_b[16*exp_gid +: 16], d, o);
            m_v[0] = exp_xfer; m_id[0] = 2'(exp_gid); m_d[0] = d; m_o[0] = o;
            if (exp_xfer) m_ptr = exp_gid;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; resp_ready = 1'b1; rand_ops();
        model_reset();
        #2;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (resp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", resp_id); else n_pass++;
        n_checks++; if (resp_data !== 16'h0000) $display("FAIL reset_data: got %h want 0000", resp_data); else n_pass++;
        n_checks++; if (resp_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", resp_ovf); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        model_eval();
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b want 0001", req_ready); else n_pass++;
        tick();
    endtask

    task automatic test_directed();
        int          ids[3] = '{0, 2, 1};
        logic [15:0] as [3] = '{16'h4000, 16'h2000, 16'h7FFF};
        logic [15:0] bs [3] = '{16'h4000, 16'hC000, 16'h7FFF};
        logic [15:0] eds[3] = '{16'h4000, 16'hE000, 16'hFFFC};
        logic        eos[3] = '{1'b0, 1'b0, 1'b1};
        logic [NREQ-1:0] oh;
        do_reset();
        resp_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            rand_ops();
            req_valid = '0;
            req_valid[ids[t]] = 1'b1;
            req_a[16*ids[t] +: 16] = as[t];
            req_b[16*ids[t] +: 16] = bs[t];
            oh = '0; oh[ids[t]] = 1'b1;
            #1;
            model_eval();
            n_checks++; if (req_ready !== oh) $display("FAIL dir%0d_grant: got %b want %b", t, req_ready, oh); else n_pass++;
            tick();
            req_valid = '0;
            for (int c = 1; c < LAT; c++) begin
                #1; model_eval(); tick();
            end
            #1;
            n_checks++; if (resp_valid !== 1'b1) $display("FAIL dir%0d_valid: got %b want 1", t, resp_valid); else n_pass++;
            n_checks++; if (resp_id !== 2'(ids[t])) $display("FAIL dir%0d_id: got %0d want %0d", t, resp_id, ids[t]); else n_pass++;
            n_checks++; if (resp_data !== eds[t]) $display("FAIL dir%0d_data: got %h want %h", t, resp_data, eds[t]); else n_pass++;
            n_checks++; if (resp_ovf !== eos[t]) $display("FAIL dir%0d_ovf: got %b want %b", t, resp_ovf, eos[t]); else n_pass++;
            model_eval();
            tick();
        end
    endtask

    task automatic test_fairness();
        int              order[6] = '{0, 1, 2, 3, 0, 1};
        logic [NREQ-1:0] oh;
        do_reset();
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int i = 0; i < 6 + LAT; i++) begin
            rand_ops();
            #1;
            model_eval();
            if (i < 6) begin
                oh = '0; oh[order[i]] = 1'b1;
                n_checks++; if (req_ready !== oh) $display("FAIL fair_grant%0d: got %b want %b", i, req_ready, oh); else n_pass++;
            end
            if (i >= LAT) begin
                n_checks++;
                if (resp_valid !== 1'b1 || resp_id !== 2'(order[i-LAT]))
                    $display("FAIL fair_resp%0d: got valid %b id %0d want valid 1 id %0d", i, resp_valid, resp_id, order[i-LAT]);
                else n_pass++;
            end
            n_checks++;
            if (exp_valid && {resp_data, resp_ovf} !== {exp_data, exp_ovf})
                $display("FAIL fair_data cyc %0d: got %h/%b want %h/%b", cyc, resp_data, resp_ovf, exp_data, exp_ovf);
            else n_pass++;
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int i = 0; i < 4 + 3 + LAT + 4; i++) begin
            resp_ready = !(i >= 4 && i < 7);
            if (i >= 7 + 2) req_valid = '0;
            rand_ops();
            #1;
            model_eval();
            if (i >= 4 && i < 7) begin
                n_checks++; if (req_ready !== 4'b0000) $display("FAIL bp_ready%0d: got %b want 0000", i, req_ready); else n_pass++;
            end
            n_checks++;
            if ({req_ready, resp_valid, busy} !== {exp_ready, exp_valid, exp_busy})
                $display("FAIL bp_ctrl cyc %0d: got %b/%b/%b want %b/%b/%b", cyc, req_ready, resp_valid, busy, exp_ready, exp_valid, exp_busy);
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if ({resp_id, resp_data, resp_ovf} !== {exp_id, exp_data, exp_ovf})
                    $display("FAIL bp_resp cyc %0d: got %0d/%h/%b want %0d/%h/%b", cyc, resp_id, resp_data, resp_ovf, exp_id, exp_data, exp_ovf);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400 + LAT + 2; i++) begin
            req_valid  = (i < 400) ? NREQ'($urandom) : '0;
            resp_ready = (i < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            rand_ops();
            #1;
            model_eval();
            n_checks++;
            if ({req_ready, resp_valid, busy} !== {exp_ready, exp_valid, exp_busy})
                $display("FAIL rnd_ctrl cyc %0d: got %b/%b/%b want %b/%b/%b", cyc, req_ready, resp_valid, busy, exp_ready, exp_valid, exp_busy);
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if ({resp_id, resp_data, resp_ovf} !== {exp_id, exp_data, exp_ovf})
                    $display("FAIL rnd_resp cyc %0d: got %0d/%h/%b want %0d/%h/%b", cyc, resp_id, resp_data, resp_ovf, exp_id, exp_data, exp_ovf);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        for (int i = 0; i < LAT; i++) begin
            rand_ops(); #1; model_eval(); tick();
        end
        req_valid = '0;
        #1;
        model_eval();
        n_checks++;
        if ({resp_valid, busy} !== {exp_valid, exp_busy})
            $display("FAIL mid_pre: got valid %b busy %b want %b %b", resp_valid, busy, exp_valid, exp_busy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", resp_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '1;
        for (int i = 0; i < LAT + 3; i++) begin
            if (i == 1) req_valid = '0;
            rand_ops();
            #1;
            model_eval();
            if (i == 0) begin
                n_checks++; if (req_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", req_ready); else n_pass++;
            end
            n_checks++;
            if ({resp_valid, busy} !== {exp_valid, exp_busy})
                $display("FAIL mid_after cyc %0d: got valid %b busy %b want %b %b", cyc, resp_valid, busy, exp_valid, exp_busy);
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if (resp_id !== exp_id) $display("FAIL mid_id cyc %0d: got %0d want %0d", cyc, resp_id, exp_id); else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        test_reset();
        test_directed();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
